// File: rtl/dfr_axi_pkg.sv
// Shared types and constants for the DFR AXI-Lite register master.
package dfr_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_DONE    = 3'd5
  } axi_mst_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // DFR configuration-register byte offsets
  localparam logic [8:0] REG_CTRL       = 9'h000;
  localparam logic [8:0] REG_DEBUG      = 9'h004;
  localparam logic [8:0] REG_MEM_ADDR   = 9'h008;
  localparam logic [8:0] REG_MEM_DATA   = 9'h00C;
  localparam logic [8:0] REG_SAMPLE_CNT = 9'h010;
  localparam logic [8:0] REG_STEP_CNT   = 9'h014;

endpackage

// File: rtl/counter.sv
// Free-running up-counter with synchronous clear and count enable.
module counter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/dfr_axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator turning register commands into
// read/write transactions, with a per-state timeout that forces a response.
module dfr_axi_lite_master
  import dfr_axi_pkg::*;
#(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 9,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic                            busy,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  axi_mst_state_t state, state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            aw_done, w_done;
  logic                            aw_hs, w_hs;
  logic [CW-1:0]                   to_cnt;
  logic                            to_hit, wait_st, cnt_rst;

  assign aw_hs   = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs    = M_AXI_WVALID && M_AXI_WREADY;
  assign to_hit  = (to_cnt == TO_LAST);
  assign wait_st = (state == ST_WR_AW_W) || (state == ST_WR_B) ||
                   (state == ST_RD_AR)   || (state == ST_RD_R);
  assign cnt_rst = rst || (state_nxt != state);

  counter #(.DATA_WIDTH(CW)) u_to_cnt (
    .clk   (clk),
    .rst   (cnt_rst),
    .en    (wait_st),
    .count (to_cnt)
  );

  // A completing handshake wins over a timeout landing in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = cmd_wr ? ST_WR_AW_W : ST_RD_AR;
      ST_WR_AW_W: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_B;
                  else if (to_hit) state_nxt = ST_DONE;
      ST_WR_B:    if (M_AXI_BVALID || to_hit) state_nxt = ST_DONE;
      ST_RD_AR:   if (M_AXI_ARREADY) state_nxt = ST_RD_R;
                  else if (to_hit) state_nxt = ST_DONE;
      ST_RD_R:    if (M_AXI_RVALID || to_hit) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= AXI_RESP_OKAY;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        ST_WR_AW_W: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        ST_WR_B: begin
          if (M_AXI_BVALID) begin
            rsp_rdata   <= '0;
            rsp_resp    <= M_AXI_BRESP;
            rsp_timeout <= 1'b0;
          end
        end
        ST_RD_R: begin
          if (M_AXI_RVALID) begin
            rsp_rdata   <= M_AXI_RDATA;
            rsp_resp    <= M_AXI_RRESP;
            rsp_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
      if (wait_st && (state_nxt == ST_DONE) &&
          !((state == ST_WR_B) && M_AXI_BVALID) &&
          !((state == ST_RD_R) && M_AXI_RVALID)) begin
        rsp_rdata   <= '0;
        rsp_resp    <= AXI_RESP_SLVERR;
        rsp_timeout <= 1'b1;
      end
    end
  end

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign rsp_valid     = (state == ST_DONE);
  assign M_AXI_AWVALID = (state == ST_WR_AW_W) && !aw_done;
  assign M_AXI_WVALID  = (state == ST_WR_AW_W) && !w_done;
  assign M_AXI_BREADY  = (state == ST_WR_B);
  assign M_AXI_ARVALID = (state == ST_RD_AR);
  assign M_AXI_RREADY  = (state == ST_RD_R);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;

endmodule

// File: tb/tb_dfr_axi_lite_master.sv
// Directed bench: reactive AXI-Lite slave with programmable latencies, a
// transaction-level response model, and per-cycle protocol checks.
module tb_dfr_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        cmd_ready, rsp_valid, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [8:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
  logic [1:0]  m_axi_bresp = '0, m_axi_rresp = '0;
  logic [31:0] m_axi_rdata = '0;

  dfr_axi_lite_master #(
    .C_M_AXI_DATA_WIDTH (32),
    .C_M_AXI_ADDR_WIDTH (9),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .M_AXI_AWADDR(m_axi_awaddr), .M_AXI_AWVALID(m_axi_awvalid), .M_AXI_AWREADY(m_axi_awready),
    .M_AXI_WDATA(m_axi_wdata), .M_AXI_WSTRB(m_axi_wstrb), .M_AXI_WVALID(m_axi_wvalid),
    .M_AXI_WREADY(m_axi_wready),
    .M_AXI_BRESP(m_axi_bresp), .M_AXI_BVALID(m_axi_bvalid), .M_AXI_BREADY(m_axi_bready),
    .M_AXI_ARADDR(m_axi_araddr), .M_AXI_ARVALID(m_axi_arvalid), .M_AXI_ARREADY(m_axi_arready),
    .M_AXI_RDATA(m_axi_rdata), .M_AXI_RRESP(m_axi_rresp), .M_AXI_RVALID(m_axi_rvalid),
    .M_AXI_RREADY(m_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) o[8*i +: 8] = n[8*i +: 8];
    return o;
  endfunction

  // Slave behaviour knobs, also consulted by the model when a command is accepted.
  int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
  bit never_ar = 0, never_b = 0;
  logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

  logic [31:0] s_mem [128];
  logic [31:0] model_mem [128];

  int  aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit  aw_got = 0, w_got = 0, wrote = 0, b_fire = 0, ar_got = 0, r_fire = 0;
  logic [8:0]  s_awaddr = '0, s_araddr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;

  task automatic slave_clear();
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
    m_axi_arready = 0; m_axi_rvalid = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; wrote = 0; b_fire = 0; ar_got = 0; r_fire = 0;
  endtask

  task automatic set_cfg(input int aw, input int w, input int b, input int ar, input int r);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
    never_ar = 0; never_b = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;
  endtask

  // Slave: decides READY/VALID at negedge; a READY raised here completes at the next posedge.
  initial forever begin
    @(negedge clk);
    if (m_axi_awready) begin m_axi_awready = 0; aw_got = 1; aw_cnt = 0; end
    else if (m_axi_awvalid === 1'b1 && !aw_got) begin
      if (aw_cnt >= aw_lat) begin m_axi_awready = 1; s_awaddr = m_axi_awaddr; end
      aw_cnt++;
    end else aw_cnt = 0;

    if (m_axi_wready) begin m_axi_wready = 0; w_got = 1; w_cnt = 0; end
    else if (m_axi_wvalid === 1'b1 && !w_got) begin
      if (w_cnt >= w_lat) begin m_axi_wready = 1; s_wdata = m_axi_wdata; s_wstrb = m_axi_wstrb; end
      w_cnt++;
    end else w_cnt = 0;

    if (b_fire) begin
      m_axi_bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0; wrote = 0; b_cnt = 0;
    end else if (aw_got && w_got) begin
      if (!wrote) begin
        s_mem[s_awaddr[8:2]] = merge(s_mem[s_awaddr[8:2]], s_wdata, s_wstrb);
        wrote = 1;
      end
      if (!never_b && b_cnt >= b_lat) begin m_axi_bvalid = 1; m_axi_bresp = bresp_cfg; end
      b_cnt++;
    end
    b_fire = m_axi_bvalid && (m_axi_bready === 1'b1);

    if (m_axi_arready) begin m_axi_arready = 0; ar_got = 1; ar_cnt = 0; r_cnt = 0; end
    else if (m_axi_arvalid === 1'b1 && !ar_got && !never_ar) begin
      if (ar_cnt >= ar_lat) begin m_axi_arready = 1; s_araddr = m_axi_araddr; end
      ar_cnt++;
    end else ar_cnt = 0;

    if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; ar_got = 0; r_cnt = 0; end
    else if (ar_got) begin
      if (r_cnt >= r_lat) begin
        m_axi_rvalid = 1; m_axi_rdata = s_mem[s_araddr[8:2]]; m_axi_rresp = rresp_cfg;
      end
      r_cnt++;
    end
    r_fire = m_axi_rvalid && (m_axi_rready === 1'b1);
  end

  typedef struct { logic [31:0] rdata; logic [1:0] resp; logic to; } exp_t;
  exp_t q[$];

  int cyc = 0, rsp_count = 0, last_cmd_cyc = 0, prev_cmd_cyc = 0, last_rsp_cyc = 0;
  int awv_cnt = 0, wv_cnt = 0, arv_cnt = 0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_resp = '0;
  logic        last_to = 0;
  logic        p_rst = 1, p_rsp = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [8:0]  p_awaddr = '0, p_araddr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;

  // Model + compare: sampled late in the cycle, after the slave has settled its inputs.
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #7;
    chk("busy", busy, q.size() != 0);
    chk("cmd_ready", cmd_ready, !busy);
    if (p_rsp) chk("rsp_single_pulse", rsp_valid, 0);
    if (rsp_valid) begin
      chk("rsp_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_resp", rsp_resp, e.resp);
        chk("rsp_timeout", rsp_timeout, e.to);
      end
      rsp_count++;
      last_rsp_cyc = cyc; last_rdata = rsp_rdata; last_resp = rsp_resp; last_to = rsp_timeout;
    end
    if (!p_rst && !(rsp_valid && rsp_timeout)) begin
      if (p_awv && p_awr) chk("awvalid_drop", m_axi_awvalid, 0);
      if (p_awv && !p_awr) begin
        chk("awvalid_hold", m_axi_awvalid, 1);
        chk("awaddr_stable", m_axi_awaddr, p_awaddr);
      end
      if (p_wv && p_wr) chk("wvalid_drop", m_axi_wvalid, 0);
      if (p_wv && !p_wr) begin
        chk("wvalid_hold", m_axi_wvalid, 1);
        chk("wdata_stable", {m_axi_wstrb, m_axi_wdata}, {p_wstrb, p_wdata});
      end
      if (p_arv && p_arr) chk("arvalid_drop", m_axi_arvalid, 0);
      if (p_arv && !p_arr) begin
        chk("arvalid_hold", m_axi_arvalid, 1);
        chk("araddr_stable", m_axi_araddr, p_araddr);
      end
    end
    if (m_axi_bready) chk("bready_after_aw_w", {m_axi_awvalid, m_axi_wvalid}, 0);
    if (m_axi_awvalid) awv_cnt++;
    if (m_axi_wvalid)  wv_cnt++;
    if (m_axi_arvalid) arv_cnt++;
    if (cmd_valid && cmd_ready && !rst) begin
      if (cmd_wr) begin
        model_mem[cmd_addr[8:2]] = merge(model_mem[cmd_addr[8:2]], cmd_wdata, cmd_wstrb);
        e.to = never_b; e.rdata = '0; e.resp = bresp_cfg;
      end else begin
        e.to = never_ar; e.rdata = model_mem[cmd_addr[8:2]]; e.resp = rresp_cfg;
      end
      if (e.to) begin e.rdata = '0; e.resp = 2'b10; end
      q.push_back(e);
      prev_cmd_cyc = last_cmd_cyc; last_cmd_cyc = cyc;
    end
    if (rst) q.delete();
    p_rst = rst; p_rsp = rsp_valid;
    p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
    p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
    p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
  end

  // Returns at #1 of the cycle after the command handshake.
  task automatic issue(input logic wr, input logic [8:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    chk("cmd_accepted", ok, 1);
  endtask

  task automatic wait_rsp(input int maxc);
    int n0;
    bit got;
    n0 = rsp_count; got = 0;
    for (int i = 0; i < maxc && !got; i++) begin
      @(posedge clk); #8;
      if (rsp_count != n0) got = 1;
    end
    chk("rsp_arrived", got, 1);
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    s_mem[w] = v; model_mem[w] = v;
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 128; i++) preload(i, 32'h0);
    preload(1, 32'hDEAD_BEEF);
    preload(2, 32'h1122_3344);
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #6;
    chk("rst_valid_ready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}, 0);

    // Zero-wait write
    issue(1, 9'h000, 32'h0000_0011, 4'hF);
    #6;
    chk("zw_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    chk("zw_awaddr", m_axi_awaddr, 9'h000);
    chk("zw_wdata", m_axi_wdata, 32'h11);
    chk("zw_wstrb", m_axi_wstrb, 4'hF);
    wait_rsp(30);
    chk("zw_wr_latency", last_rsp_cyc - last_cmd_cyc, 3);
    chk("zw_wr_resp", {last_to, last_resp}, 3'b000);
    @(posedge clk); #6;
    chk("zw_idle_after", {cmd_ready, busy}, 2'b10);

    // Zero-wait read back of the write
    issue(0, 9'h000, 32'h0, 4'h0);
    wait_rsp(30);
    chk("zw_rd_latency", last_rsp_cyc - last_cmd_cyc, 3);
    chk("zw_rd_data", last_rdata, 32'h11);

    // Read with ARREADY stall and late RVALID
    set_cfg(0, 0, 0, 3, 1);
    arv_cnt = 0;
    issue(0, 9'h004, 32'h0, 4'h0);
    wait_rsp(30);
    chk("stall_arvalid_cycles", arv_cnt, 4);
    chk("stall_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("stall_resp", {last_to, last_resp}, 3'b000);

    // Split handshakes: W first, then AW first
    set_cfg(6, 1, 0, 0, 0);
    awv_cnt = 0; wv_cnt = 0; n0 = rsp_count;
    issue(1, 9'h008, 32'hAABB_CCDD, 4'b0101);
    wait_rsp(40);
    chk("split1_wvalid_cycles", wv_cnt, 2);
    chk("split1_awvalid_cycles", awv_cnt, 7);
    set_cfg(0, 3, 2, 0, 0);
    awv_cnt = 0; wv_cnt = 0;
    issue(1, 9'h00C, 32'h5555_0000, 4'b1100);
    wait_rsp(40);
    chk("split2_awvalid_cycles", awv_cnt, 1);
    chk("split2_wvalid_cycles", wv_cnt, 4);
    chk("split_rsp_count", rsp_count - n0, 2);
    set_cfg(0, 0, 0, 0, 0);
    issue(0, 9'h008, 32'h0, 4'h0);
    wait_rsp(30);
    chk("strobe_merge", last_rdata, 32'h11BB_33DD);

    // Slave error response
    set_cfg(0, 0, 0, 0, 0);
    bresp_cfg = 2'b10;
    issue(1, 9'h010, 32'h0000_0100, 4'hF);
    wait_rsp(30);
    chk("err_resp", {last_to, last_resp}, 3'b010);

    // Timeout: ARREADY never comes
    set_cfg(0, 0, 0, 0, 0);
    never_ar = 1;
    arv_cnt = 0;
    issue(0, 9'h00C, 32'h0, 4'h0);
    wait_rsp(60);
    chk("to_arvalid_cycles", arv_cnt, 16);
    chk("to_latency", last_rsp_cyc - last_cmd_cyc, 17);
    chk("to_resp", {last_to, last_resp, last_rdata}, {1'b1, 2'b10, 32'h0});
    slave_clear();
    never_ar = 0;
    issue(0, 9'h004, 32'h0, 4'h0);
    wait_rsp(30);
    chk("post_to_read", {last_to, last_rdata}, {1'b0, 32'hDEAD_BEEF});

    // Held cmd_valid is only taken once the previous response has gone out
    set_cfg(0, 0, 0, 0, 0);
    n0 = rsp_count;
    issue(1, 9'h014, 32'h0000_0007, 4'hF);
    issue(0, 9'h014, 32'h0, 4'h0);
    chk("block_accept_gap", last_cmd_cyc - prev_cmd_cyc, 4);
    chk("block_rsp_before_accept", rsp_count - n0, 1);
    wait_rsp(30);
    chk("block_rd_data", last_rdata, 32'h7);

    // Reset while waiting in WR_B
    never_b = 1;
    issue(1, 9'h000, 32'hFFFF_FFFF, 4'hF);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #7;
        if (m_axi_bready) seen = 1;
      end
      chk("reached_wr_b", seen, 1);
    end
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    n0 = rsp_count;
    #6;
    chk("midrst_valid_ready", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
    chk("midrst_busy_rsp", {busy, rsp_valid}, 2'b00);
    slave_clear();
    never_b = 0;
    repeat (4) @(posedge clk);
    #7;
    chk("midrst_no_rsp", rsp_count - n0, 0);
    // Slave took the aborted write; resync the model with it
    model_mem[0] = s_mem[0];
    issue(0, 9'h000, 32'h0, 4'h0);
    wait_rsp(30);
    chk("post_rst_read_ok", {last_to, last_resp}, 3'b000);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
